rng_reseed_ctrl: RTL and testbench

RNG_RESEED_CTRL -- requirements
Module: rng_reseed_ctrl

---
 rtl/rng_pkg.sv | 32 +++
 rtl/rng_popcount32.sv | 22 ++
 rtl/rng_reseed_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_rng_reseed_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rng_pkg
//  Description : Shared types and constants for the RNG reseed controller.
//                Holds the controller state encoding, the fail_cause bit
//                positions and the default parameter values.
//  Revision    : 1.0 - initial release
// ============================================================================
package rng_pkg;

    // Controller state: normal sampling, one-cycle reseed strobe,
    // then a settle period while the generator absorbs the new seed.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Bit positions within fail_cause
    localparam int c_fc_rep  = 0;
    localparam int c_fc_mono = 1;

    // Default parameter values
    localparam int c_def_reseed_interval = 1024;
    localparam int c_def_rep_limit       = 4;
    localparam int c_def_win_log2        = 8;
    localparam int c_def_ones_lo         = 3900;
    localparam int c_def_ones_hi         = 4292;
    localparam int c_def_settle_cycles   = 2;

endpackage
`default_nettype wire

// File: rtl/rng_popcount32.sv
`default_nettype none
// ============================================================================
//  Module      : rng_popcount32
//  Description : Combinational ones counter for one 32-bit sample.
//  Ports       : din  [31:0] in  - sample
//                ones [5:0]  out - number of set bits in din (0..32)
//  Revision    : 1.0 - initial release
// ============================================================================
module rng_popcount32 (
    input  logic [31:0] din,
    output logic [5:0]  ones
);

    always_comb begin
        ones = '0;
        for (int i = 0; i < 32; i++) begin
            ones = ones + {5'd0, din[i]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/rng_reseed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rng_reseed_ctrl
//  Description : Health-monitors a random generator (repetition count test,
//                optional monobit window test), and issues reseeds on a test
//                failure, after RESEED_INTERVAL valid samples, or on software
//                request. Several triggers in one cycle produce one reseed.
//  Macro       : RNG_MONOBIT_EN - when defined, the monobit window test and
//                its accumulator are built; otherwise fail_cause[1] is 0.
//  Ports       : clk, rst_n            clock / async active-low reset
//                rnd[31:0], rnd_valid  generator sample and its strobe
//                sw_req, sw_seed[31:0] software reseed request / base seed
//                seed[31:0], re_seed   seed to generator and one-cycle strobe
//                fail, fail_cause[1:0] sticky failure and its causes
//                fail_clr              clears fail / fail_cause
//                reseed_count[15:0]    wrapping count of issued reseeds
//                busy                  high while in ISSUE or SETTLE
//  Revision    : 1.0 - initial release
// ============================================================================
module rng_reseed_ctrl
    import rng_pkg::*;
#(
    parameter int RESEED_INTERVAL = c_def_reseed_interval,
    parameter int REP_LIMIT       = c_def_rep_limit,
    parameter int WIN_LOG2        = c_def_win_log2,
    parameter int ONES_LO         = c_def_ones_lo,
    parameter int ONES_HI         = c_def_ones_hi,
    parameter int SETTLE_CYCLES   = c_def_settle_cycles
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rnd,
    input  logic        rnd_valid,
    input  logic        sw_req,
    input  logic [31:0] sw_seed,
    output logic [31:0] seed,
    output logic        re_seed,
    output logic        fail,
    output logic [1:0]  fail_cause,
    input  logic        fail_clr,
    output logic [15:0] reseed_count,
    output logic        busy
);

    localparam int c_run_w = $clog2(REP_LIMIT + 1);
    localparam int c_int_w = $clog2(RESEED_INTERVAL + 1);
    localparam int c_set_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_set_w-1:0]   r_settle_cnt;
    logic [31:0]          r_prev;
    logic                 r_prev_vld;
    logic [c_run_w-1:0]   r_run;
    logic [c_run_w-1:0]   w_run_next;
    logic [c_int_w-1:0]   r_int;
    logic [c_int_w-1:0]   w_int_next;
    logic                 r_pending;
    logic [31:0]          r_seed;
    logic [15:0]          r_count;
    logic                 r_fail_rep;
    logic                 w_fail_mono;

    logic w_sample;
    logic w_rep_hit;
    logic w_int_hit;
    logic w_mono_hit;
    logic w_sw_trig;
    logic w_trig;

    // Only samples seen while running feed the health tests.
    assign w_sample   = (r_state == ST_RUN) && rnd_valid;

    // Run length restarts at 1 for the first sample or any change of value.
    assign w_run_next = (r_prev_vld && (rnd == r_prev)) ? (r_run + c_run_w'(1))
                                                        : c_run_w'(1);
    assign w_rep_hit  = w_sample && (w_run_next == c_run_w'(REP_LIMIT));

    assign w_int_next = r_int + c_int_w'(1);
    assign w_int_hit  = w_sample && (w_int_next == c_int_w'(RESEED_INTERVAL));

    // A request arriving in the same RUN cycle counts immediately, so it
    // merges with any test trigger of that cycle into one reseed.
    assign w_sw_trig  = (r_state == ST_RUN) && (r_pending || sw_req);
    assign w_trig     = w_rep_hit || w_int_hit || w_mono_hit || w_sw_trig;

`ifdef RNG_MONOBIT_EN
    localparam int c_acc_w = WIN_LOG2 + 6;

    logic [5:0]          w_ones;
    logic [c_acc_w-1:0]  r_acc;
    logic [c_acc_w-1:0]  w_acc_sum;
    logic [WIN_LOG2-1:0] r_win;
    logic                w_win_last;
    logic                r_fail_mono;

    rng_popcount32 u_popcount (
        .din  (rnd),
        .ones (w_ones)
    );

    assign w_acc_sum  = r_acc + c_acc_w'(w_ones);
    assign w_win_last = &r_win;
    // The window is judged on the sum including its final sample.
    assign w_mono_hit = w_sample && w_win_last &&
                        ((w_acc_sum < c_acc_w'(ONES_LO)) ||
                         (w_acc_sum > c_acc_w'(ONES_HI)));
    assign w_fail_mono = r_fail_mono;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_win       <= '0;
            r_fail_mono <= 1'b0;
        end else begin
            if (w_trig || (w_sample && w_win_last)) begin
                r_acc <= '0;
                r_win <= '0;
            end else if (w_sample) begin
                r_acc <= w_acc_sum;
                r_win <= r_win + WIN_LOG2'(1);
            end
            // A coincident new failure wins over the clear.
            r_fail_mono <= (r_fail_mono && !fail_clr) || w_mono_hit;
        end
    end
`else
    assign w_mono_hit  = 1'b0;
    assign w_fail_mono = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        re_seed      = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_RUN: begin
                busy = 1'b0;
                if (w_trig) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                re_seed      = 1'b1;
                w_state_next = (SETTLE_CYCLES == 0) ? ST_RUN : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_settle_cnt == c_set_w'(SETTLE_CYCLES - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
        end else if (r_state == ST_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + c_set_w'(1);
        end else begin
            r_settle_cnt <= '0;
        end
    end

    // ------------------------------------------- test state, seed, status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_run      <= '0;
            r_int      <= '0;
            r_pending  <= 1'b0;
            r_seed     <= '0;
            r_count    <= '0;
            r_fail_rep <= 1'b0;
        end else begin
            // Any trigger from RUN consumes the request, so pending only
            // survives for requests raised while busy.
            if (w_trig) begin
                r_pending <= 1'b0;
            end else begin
                r_pending <= r_pending || sw_req;
            end

            if (w_trig) begin
                // Seed is captured on entry to ISSUE using the count before
                // this reseed's increment, then held until the next ISSUE.
                r_seed     <= w_sw_trig ? sw_seed : (sw_seed ^ {r_count, r_count});
                r_prev_vld <= 1'b0;
                r_run      <= '0;
                r_int      <= '0;
            end else if (w_sample) begin
                r_prev     <= rnd;
                r_prev_vld <= 1'b1;
                r_run      <= w_run_next;
                r_int      <= w_int_next;
            end

            if (r_state == ST_ISSUE) begin
                r_count <= r_count + 16'd1;
            end

            r_fail_rep <= (r_fail_rep && !fail_clr) || w_rep_hit;
        end
    end

    assign seed                  = r_seed;
    assign reseed_count          = r_count;
    assign fail_cause[c_fc_rep]  = r_fail_rep;
    assign fail_cause[c_fc_mono] = w_fail_mono;
    assign fail                  = r_fail_rep || w_fail_mono;

endmodule
`default_nettype wire

// File: tb/tb_rng_reseed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rng_reseed_ctrl
//  Description : Directed self-checking bench for rng_reseed_ctrl.
//                DUT uses RESEED_INTERVAL=16, REP_LIMIT=4, SETTLE_CYCLES=2
//                and an 8-sample monobit window (WIN_LOG2=3, bounds 112..144)
//                so that every scenario fits between periodic reseeds.
//                Monobit scenarios are built only with RNG_MONOBIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rng_reseed_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] rnd;
    logic        rnd_valid;
    logic        sw_req;
    logic [31:0] sw_seed;
    logic [31:0] seed;
    logic        re_seed;
    logic        fail;
    logic [1:0]  fail_cause;
    logic        fail_clr;
    logic [15:0] reseed_count;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    rng_reseed_ctrl #(
        .RESEED_INTERVAL (16),
        .REP_LIMIT       (4),
        .WIN_LOG2        (3),
        .ONES_LO         (112),
        .ONES_HI         (144),
        .SETTLE_CYCLES   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rnd          (rnd),
        .rnd_valid    (rnd_valid),
        .sw_req       (sw_req),
        .sw_seed      (sw_seed),
        .seed         (seed),
        .re_seed      (re_seed),
        .fail         (fail),
        .fail_cause   (fail_cause),
        .fail_clr     (fail_clr),
        .reseed_count (reseed_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs changed 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Rotation of 0x0000FFFF: distinct values, each with exactly 16 ones.
    function automatic logic [31:0] rot16(input int i);
        logic [31:0] base;
        base = 32'h0000FFFF;
        return (base << i) | (base >> (32 - i));
    endfunction

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        rnd       = '0;
        rnd_valid = 1'b0;
        sw_req    = 1'b0;
        sw_seed   = 32'h12345678;
        fail_clr  = 1'b0;
        tick(); tick();
        chk("rst_seed",    seed,         32'h0);
        chk("rst_re_seed", re_seed,      32'h0);
        chk("rst_fail",    fail,         32'h0);
        chk("rst_cause",   fail_cause,   32'h0);
        chk("rst_count",   reseed_count, 32'h0);
        chk("rst_busy",    busy,         32'h0);
        rst_n = 1'b1;
        tick();

        // Four identical zero samples -> repetition failure and reseed
        for (int i = 0; i < 4; i++) begin
            rnd = 32'h0; rnd_valid = 1'b1;
            tick();
            if (i == 2) chk("rep_no_early", re_seed, 32'h0);
        end
        rnd_valid = 1'b0;
        chk("rep_re_seed", re_seed,      32'h1);
        chk("rep_seed",    seed,         32'h12345678);
        chk("rep_cause",   fail_cause,   32'h1);
        chk("rep_fail",    fail,         32'h1);
        chk("rep_busy",    busy,         32'h1);
        tick();
        chk("rep_strobe_1cyc", re_seed,      32'h0);
        chk("rep_count",       reseed_count, 32'h1);
        tick(); tick();
        chk("rep_back_run", busy, 32'h0);

        fail_clr = 1'b1; tick(); fail_clr = 1'b0;
        chk("clr_fail",  fail,       32'h0);
        chk("clr_cause", fail_cause, 32'h0);

        // Periodic reseed after 16 distinct samples (count 1, then 2)
        for (int i = 0; i < 16; i++) begin
            rnd = rot16(i); rnd_valid = 1'b1;
            tick();
            if (i == 14) chk("int_no_early", re_seed, 32'h0);
        end
        rnd_valid = 1'b0;
        chk("int_re_seed", re_seed, 32'h1);
        chk("int_seed1",   seed,    32'h12355679);
        chk("int_no_fail", fail,    32'h0);
        tick(); tick(); tick();
        for (int i = 16; i < 32; i++) begin
            rnd = rot16(i); rnd_valid = 1'b1;
            tick();
        end
        rnd_valid = 1'b0;
        chk("int_re_seed2", re_seed, 32'h1);
        chk("int_seed2",    seed,    32'h1236567A);
        tick(); tick(); tick();
        chk("int_count", reseed_count, 32'h3);

        // Software request in RUN, then another raised during SETTLE
        sw_seed = 32'hA5A50001; sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        chk("sw_re_seed", re_seed, 32'h1);
        chk("sw_seed",    seed,    32'hA5A50001);
        tick();
        sw_seed = 32'h0BADF00D; sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
        chk("sw_settle_quiet", re_seed, 32'h0);
        chk("sw_settle_busy",  busy,    32'h1);
        tick();
        chk("sw_run_cycle", re_seed, 32'h0);
        chk("sw_run_idle",  busy,    32'h0);
        tick();
        chk("sw_pend_re_seed", re_seed,      32'h1);
        chk("sw_pend_seed",    seed,         32'h0BADF00D);
        chk("sw_pend_count",   reseed_count, 32'h4);
        tick(); tick(); tick(); tick();
        chk("sw_no_extra", re_seed,      32'h0);
        chk("sw_count",    reseed_count, 32'h5);

        // Repetition trigger and software request in the same cycle
        sw_seed = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            rnd = 32'h5A5A5A5A; rnd_valid = 1'b1;
            sw_req = (i == 3);
            tick();
        end
        rnd_valid = 1'b0; sw_req = 1'b0;
        chk("both_re_seed", re_seed,    32'h1);
        chk("both_seed",    seed,       32'h12345678);
        chk("both_cause",   fail_cause, 32'h1);
        tick(); tick(); tick(); tick();
        chk("both_single", re_seed,      32'h0);
        chk("both_count",  reseed_count, 32'h6);

        // fail_clr coinciding with a new repetition failure
        for (int i = 0; i < 4; i++) begin
            rnd = 32'h3C3C3C3C; rnd_valid = 1'b1;
            fail_clr = (i == 3);
            tick();
        end
        rnd_valid = 1'b0; fail_clr = 1'b0;
        chk("clrnew_fail",  fail,       32'h1);
        chk("clrnew_cause", fail_cause, 32'h1);
        chk("clrnew_seed",  seed,       32'h1232567E);
        tick(); tick(); tick();
        fail_clr = 1'b1; tick(); fail_clr = 1'b0;
        chk("clr2_fail", fail, 32'h0);

`ifdef RNG_MONOBIT_EN
        // 8-sample window of 32/31 ones -> 252 > 144
        for (int i = 0; i < 8; i++) begin
            rnd = (i % 2 == 0) ? 32'hFFFFFFFF : 32'hFFFFFFFE; rnd_valid = 1'b1;
            tick();
            if (i == 6) chk("mono_no_early", re_seed, 32'h0);
        end
        rnd_valid = 1'b0;
        chk("mono_re_seed", re_seed,    32'h1);
        chk("mono_cause",   fail_cause, 32'h2);
        chk("mono_fail",    fail,       32'h1);
        chk("mono_seed",    seed,       32'h1233567F);
        tick(); tick(); tick();
        fail_clr = 1'b1; tick(); fail_clr = 1'b0;
`endif

        // Asynchronous reset in the middle of SETTLE
        sw_req = 1'b1; tick(); sw_req = 1'b0;
        tick();
        chk("arst_pre_busy", busy, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seed",    seed,         32'h0);
        chk("arst_re_seed", re_seed,      32'h0);
        chk("arst_fail",    fail,         32'h0);
        chk("arst_cause",   fail_cause,   32'h0);
        chk("arst_count",   reseed_count, 32'h0);
        chk("arst_busy",    busy,         32'h0);
        tick();
        rst_n = 1'b1;
        sw_seed = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            rnd = 32'hAAAA5555; rnd_valid = 1'b1;
            tick();
            chk("post_rst_quiet", re_seed, 32'h0);
        end
        rnd_valid = 1'b0;
        tick();
        chk("post_rst_hold", busy, 32'h0);
        rnd_valid = 1'b1;
        tick();
        rnd_valid = 1'b0;
        chk("post_rst_4th",   re_seed,      32'h1);
        chk("post_rst_seed",  seed,         32'h12345678);
        chk("post_rst_count", reseed_count, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
